// File: rtl/aes_selftest_pkg.sv
// Shared types and constants for the AES known-answer self-test sequencer.
// Holds the FSM state type, round-count helpers and FIPS-197 test vectors.
package aes_selftest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENC,
        CAPT,
        DEC,
        CHECK,
        DONE
    } state_e;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    // FIPS-197 appendix C known-answer vectors
    localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] FIPS_KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] FIPS_KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] FIPS_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

endpackage

// File: rtl/aes_phase_timer.sv
// Loadable round counter shared by the encrypt and decrypt phases.
// term_o is high while the count equals NR, i.e. on the last cycle of a phase.
module aes_phase_timer #(
    parameter int NR    = 10,
    parameter int CNT_W = $clog2(NR + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == CNT_W'(NR));

endmodule

// File: rtl/aes_selftest_ctrl.sv
// AES known-answer self-test sequencer: encrypt, capture, decrypt, compare.
// Define AES_SELFTEST_LOOP_EN for continuous looping with run_cnt and fail_sticky outputs.
module aes_selftest_ctrl
    import aes_selftest_pkg::*;
#(
    parameter int NK    = 4,
    parameter int NR    = nr_of(NK),
    parameter int CNT_W = $clog2(NR + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    input  logic [127:0]     plain_in,
    input  logic [127:0]     expected_ct,
    output logic [32*NK-1:0] key_out,
    output logic [127:0]     pt_out,
    output logic             enc_rst,
    input  logic [127:0]     enc_out,
    output logic             dec_rst,
    output logic [127:0]     ct_out,
    input  logic [127:0]     dec_out,
    input  logic             disp_src,
    input  logic [3:0]       disp_idx,
    output logic [7:0]       disp_byte,
    output logic             busy,
    output logic             done,
    output logic             pass_enc,
    output logic             pass_dec
`ifdef AES_SELFTEST_LOOP_EN
    ,
    output logic [15:0]      run_cnt,
    output logic             fail_sticky
`endif
);

    if (!nk_legal(NK)) begin : g_nk_illegal
        $error("aes_selftest_ctrl: NK must be 4, 6 or 8");
    end

    state_e           state_q, state_d;
    logic             accept;
    logic             tmr_load, tmr_en, tmr_term;

    logic [32*NK-1:0] key_q, key_d;
    logic [127:0]     pt_q, pt_d;
    logic [127:0]     exp_q, exp_d;
    logic [127:0]     ct_q, ct_d;
    logic [127:0]     pt_rec_q, pt_rec_d;
    logic             pass_enc_q, pass_enc_d;
    logic             pass_dec_q, pass_dec_d;
    logic [7:0]       disp_q, disp_d;
    logic [127:0]     disp_word;
    logic [3:0]       byte_sel;

`ifdef AES_SELFTEST_LOOP_EN
    logic             keep_q, keep_d;
    logic [15:0]      run_cnt_q, run_cnt_d;
    logic             fail_q, fail_d;
`endif

    assign accept = (state_q == IDLE) && start;

    aes_phase_timer #(
        .NR    (NR),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .term_o (tmr_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ENC;
            ENC:     if (tmr_term) state_d = CAPT;
            CAPT:    state_d = DEC;
            DEC:     if (tmr_term) state_d = CHECK;
            CHECK:   state_d = DONE;
`ifdef AES_SELFTEST_LOOP_EN
            DONE:    state_d = (keep_q && start) ? ENC : IDLE;
`else
            DONE:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Cipher cores are held in reset outside their own phase; the timer reloads between phases.
    always_comb begin
        enc_rst = 1'b1;
        dec_rst = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE:    busy = 1'b0;
            ENC: begin
                enc_rst = 1'b0;
                tmr_en  = 1'b1;
            end
            DEC: begin
                dec_rst = 1'b0;
                tmr_en  = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign tmr_load = ~tmr_en;

    // Byte 0 is the most significant byte of the selected word.
    assign disp_word = disp_src ? pt_rec_q : ct_q;
    assign byte_sel  = 4'd15 - disp_idx;

    always_comb begin
        key_d      = key_q;
        pt_d       = pt_q;
        exp_d      = exp_q;
        ct_d       = ct_q;
        pt_rec_d   = pt_rec_q;
        pass_enc_d = pass_enc_q;
        pass_dec_d = pass_dec_q;
        disp_d     = disp_word[{byte_sel, 3'b000} +: 8];
        if (accept) begin
            key_d      = key_in;
            pt_d       = plain_in;
            exp_d      = expected_ct;
            pass_enc_d = 1'b0;
            pass_dec_d = 1'b0;
        end
        if (state_q == CAPT) begin
            ct_d       = enc_out;
            pass_enc_d = (enc_out == exp_q);
        end
        if (state_q == CHECK) begin
            pt_rec_d   = dec_out;
            pass_dec_d = (dec_out == pt_q);
        end
    end

`ifdef AES_SELFTEST_LOOP_EN
    // Dropping start at any point of a run ends the loop after that run's DONE.
    always_comb begin
        keep_d    = keep_q;
        run_cnt_d = run_cnt_q;
        fail_d    = fail_q;
        if (accept) begin
            keep_d = 1'b1;
        end else if (busy && !start) begin
            keep_d = 1'b0;
        end
        if (state_q == DONE) begin
            if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
            if (!(pass_enc_q && pass_dec_q)) fail_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q      <= '0;
            pt_q       <= '0;
            exp_q      <= '0;
            ct_q       <= '0;
            pt_rec_q   <= '0;
            pass_enc_q <= 1'b0;
            pass_dec_q <= 1'b0;
            disp_q     <= '0;
`ifdef AES_SELFTEST_LOOP_EN
            keep_q     <= 1'b0;
            run_cnt_q  <= '0;
            fail_q     <= 1'b0;
`endif
        end else begin
            key_q      <= key_d;
            pt_q       <= pt_d;
            exp_q      <= exp_d;
            ct_q       <= ct_d;
            pt_rec_q   <= pt_rec_d;
            pass_enc_q <= pass_enc_d;
            pass_dec_q <= pass_dec_d;
            disp_q     <= disp_d;
`ifdef AES_SELFTEST_LOOP_EN
            keep_q     <= keep_d;
            run_cnt_q  <= run_cnt_d;
            fail_q     <= fail_d;
`endif
        end
    end

    assign key_out   = key_q;
    assign pt_out    = pt_q;
    assign ct_out    = ct_q;
    assign disp_byte = disp_q;
    assign pass_enc  = pass_enc_q;
    assign pass_dec  = pass_dec_q;
`ifdef AES_SELFTEST_LOOP_EN
    assign run_cnt     = run_cnt_q;
    assign fail_sticky = fail_q;
`endif

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Self-checking bench: three sequencers (NK=4/6/8) driving behavioural Cipher/InvCipher stand-ins,
// checked against a run-level reference model (FIPS vectors plus an invertible mock cipher).
`timescale 1ns/1ps
module tb_aes_selftest_ctrl;
    import aes_selftest_pkg::*;

    localparam int NU = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start_a       [NU];
    logic [255:0] key_in_a      [NU];
    logic [127:0] plain_a       [NU];
    logic [127:0] exp_a         [NU];
    logic         disp_src_a    [NU];
    logic [3:0]   disp_idx_a    [NU];
    logic         corrupt_dec_a [NU];

    logic [255:0] key_out_a   [NU];
    logic [127:0] pt_out_a    [NU];
    logic [127:0] ct_out_a    [NU];
    logic         enc_rst_a   [NU];
    logic         dec_rst_a   [NU];
    logic         busy_a      [NU];
    logic         done_a      [NU];
    logic         pass_enc_a  [NU];
    logic         pass_dec_a  [NU];
    logic [7:0]   disp_byte_a [NU];
    int           done_cnt_a  [NU];
`ifdef AES_SELFTEST_LOOP_EN
    logic [15:0]  run_cnt_a     [NU];
    logic         fail_sticky_a [NU];
`endif

    logic [127:0] model_ct  [NU];
    logic [127:0] model_rec [NU];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in cipher: the FIPS vectors map exactly; anything else uses an invertible rotate/xor.
    function automatic logic [127:0] fold(input logic [255:0] k);
        return k[127:0] ^ k[255:128];
    endfunction

    function automatic logic [127:0] enc_model(input logic [255:0] k, input int nk, input logic [127:0] p);
        if (p == FIPS_PT && nk == 4 && k == 256'(FIPS_KEY128)) return FIPS_CT128;
        if (p == FIPS_PT && nk == 6 && k == 256'(FIPS_KEY192)) return FIPS_CT192;
        if (p == FIPS_PT && nk == 8 && k == FIPS_KEY256)       return FIPS_CT256;
        return {p[120:0], p[127:121]} ^ fold(k);
    endfunction

    function automatic logic [127:0] dec_model(input logic [255:0] k, input int nk, input logic [127:0] c);
        logic [127:0] t;
        if (c == FIPS_CT128 && nk == 4 && k == 256'(FIPS_KEY128)) return FIPS_PT;
        if (c == FIPS_CT192 && nk == 6 && k == 256'(FIPS_KEY192)) return FIPS_PT;
        if (c == FIPS_CT256 && nk == 8 && k == FIPS_KEY256)       return FIPS_PT;
        t = c ^ fold(k);
        return {t[6:0], t[127:7]};
    endfunction

    for (genvar g = 0; g < NU; g++) begin : g_u
        localparam int GNK = 4 + 2 * g;
        localparam int GNR = nr_of(GNK);
        logic [32*GNK-1:0] ko;
        logic [127:0] po, co, eo, dq;
        logic ers, drs, bsy, dn, pe, pd;
        logic [7:0] db;
        int ecnt = 0;
        int dcnt = 0;
        int dones = 0;
`ifdef AES_SELFTEST_LOOP_EN
        logic [15:0] rc;
        logic fs;
`endif

        aes_selftest_ctrl #(.NK(GNK)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start_a[g]),
            .key_in      (key_in_a[g][32*GNK-1:0]),
            .plain_in    (plain_a[g]),
            .expected_ct (exp_a[g]),
            .key_out     (ko),
            .pt_out      (po),
            .enc_rst     (ers),
            .enc_out     (eo),
            .dec_rst     (drs),
            .ct_out      (co),
            .dec_out     (dq),
            .disp_src    (disp_src_a[g]),
            .disp_idx    (disp_idx_a[g]),
            .disp_byte   (db),
            .busy        (bsy),
            .done        (dn),
            .pass_enc    (pe),
            .pass_dec    (pd)
`ifdef AES_SELFTEST_LOOP_EN
            ,
            .run_cnt     (rc),
            .fail_sticky (fs)
`endif
        );

        // Iterative cores need NR+1 clocks out of reset; the result appears on the last one.
        always @(posedge clk) begin
            if (ers) begin
                ecnt <= 0;
                eo   <= '0;
            end else begin
                ecnt <= ecnt + 1;
                if (ecnt == GNR) eo <= enc_model(256'(ko), GNK, po);
            end
            if (drs) begin
                dcnt <= 0;
                dq   <= '0;
            end else begin
                dcnt <= dcnt + 1;
                if (dcnt == GNR) dq <= dec_model(256'(ko), GNK, co) ^ 128'(corrupt_dec_a[g]);
            end
        end

        always @(negedge clk) if (dn) dones <= dones + 1;

        assign key_out_a[g]   = 256'(ko);
        assign pt_out_a[g]    = po;
        assign ct_out_a[g]    = co;
        assign enc_rst_a[g]   = ers;
        assign dec_rst_a[g]   = drs;
        assign busy_a[g]      = bsy;
        assign done_a[g]      = dn;
        assign pass_enc_a[g]  = pe;
        assign pass_dec_a[g]  = pd;
        assign disp_byte_a[g] = db;
        assign done_cnt_a[g]  = dones;
`ifdef AES_SELFTEST_LOOP_EN
        assign run_cnt_a[g]     = rc;
        assign fail_sticky_a[g] = fs;
`endif
    end

    function automatic logic [255:0] key_mask(input int u);
        logic [255:0] one = 256'd1;
        return (one << (32 * (4 + 2 * u))) - one;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_run(input int u, input logic [255:0] key_raw, input logic [127:0] pt,
                          input logic [127:0] exp, input logic corrupt, input bit disturb,
                          input string tag);
        int nk = 4 + 2 * u;
        int nr = nr_of(nk);
        int k;
        int d0;
        logic [255:0] key;
        logic [127:0] ct_m, rec_m;
        key   = key_raw & key_mask(u);
        ct_m  = enc_model(key, nk, pt);
        rec_m = dec_model(key, nk, ct_m) ^ 128'(corrupt);
        @(negedge clk);
        key_in_a[u] = key; plain_a[u] = pt; exp_a[u] = exp;
        corrupt_dec_a[u] = corrupt; start_a[u] = 1'b1;
        d0 = done_cnt_a[u];
        @(posedge clk);
        @(negedge clk);
        start_a[u] = 1'b0;
        k = 0;
        while (!done_a[u] && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 3) begin
                check($sformatf("%s_pe_clr", tag), pass_enc_a[u], 1'b0);
                check($sformatf("%s_pd_clr", tag), pass_dec_a[u], 1'b0);
                check($sformatf("%s_enc_rst_enc", tag), {enc_rst_a[u], dec_rst_a[u], busy_a[u]}, 3'b011);
            end
            if (k == nr + 3)
                check($sformatf("%s_rst_dec", tag), {enc_rst_a[u], dec_rst_a[u]}, 2'b10);
            if (disturb && k == 5) begin
                start_a[u] = 1'b1; key_in_a[u] = rand256(); plain_a[u] = rand128(); exp_a[u] = rand128();
            end
            if (disturb && k == 6) start_a[u] = 1'b0;
        end
        check($sformatf("%s_latency", tag), k, 2 * nr + 4);
        check($sformatf("%s_ct", tag), ct_out_a[u], ct_m);
        check($sformatf("%s_pass_enc", tag), pass_enc_a[u], ct_m == exp);
        check($sformatf("%s_pass_dec", tag), pass_dec_a[u], rec_m == pt);
        check($sformatf("%s_key_out", tag), key_out_a[u], key);
        check($sformatf("%s_pt_out", tag), pt_out_a[u], pt);
        @(negedge clk);
        check($sformatf("%s_done_len", tag), done_a[u], 1'b0);
        #1;
        check($sformatf("%s_done_cnt", tag), done_cnt_a[u] - d0, 1);
        model_ct[u]  = ct_m;
        model_rec[u] = rec_m;
    endtask

    task automatic disp_check(input int u, input logic src, input logic [3:0] idx, input string tag);
        logic [127:0] w;
        @(negedge clk);
        disp_src_a[u] = src; disp_idx_a[u] = idx;
        @(posedge clk);
        #1;
        w = src ? model_rec[u] : model_ct[u];
        check(tag, disp_byte_a[u], (w >> (8 * (15 - int'(idx)))) & 128'hff);
    endtask

    task automatic wait_done(input int u, input string tag, output int t);
        int n = 0;
        @(negedge clk);
        while (!done_a[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_a[u], 1'b1);
        t = cyc;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t1, t2, t3;
        logic [255:0] rk;
        logic [127:0] rp, rct, re;
        for (int u = 0; u < NU; u++) begin
            start_a[u] = 1'b0; key_in_a[u] = '0; plain_a[u] = '0; exp_a[u] = '0;
            disp_src_a[u] = 1'b0; disp_idx_a[u] = '0; corrupt_dec_a[u] = 1'b0;
            model_ct[u] = '0; model_rec[u] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check($sformatf("reset_ctl_u%0d", u),
                  {busy_a[u], done_a[u], enc_rst_a[u], dec_rst_a[u], pass_enc_a[u], pass_dec_a[u]}, 6'b001100);
            check($sformatf("reset_data_u%0d", u), key_out_a[u] | 256'(pt_out_a[u]) | 256'(ct_out_a[u]), 0);
            check($sformatf("reset_disp_u%0d", u), disp_byte_a[u], 8'h00);
        end
        reset = 1'b0;
        disp_check(0, 1'b1, 4'd3, "reset_pt_rec");

        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128, 1'b0, 1'b0, "fips128");
        disp_check(0, 1'b0, 4'd15, "disp_ct_lsb");
        check("disp_5a", disp_byte_a[0], 8'h5a);
        disp_check(0, 1'b0, 4'd0, "disp_ct_msb");
        disp_check(0, 1'b1, 4'd15, "disp_pt_lsb");
        do_run(1, 256'(FIPS_KEY192), FIPS_PT, FIPS_CT192, 1'b0, 1'b0, "fips192");
        do_run(2, FIPS_KEY256, FIPS_PT, FIPS_CT256, 1'b0, 1'b0, "fips256");

        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128 ^ 128'd1, 1'b0, 1'b0, "exp_flip");
        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128, 1'b1, 1'b0, "dec_bad");
        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128, 1'b0, 1'b1, "disturb");

        // Asynchronous reset in the middle of a run, asserted between clock edges.
        @(negedge clk);
        key_in_a[0] = 256'(FIPS_KEY128); plain_a[0] = FIPS_PT; exp_a[0] = FIPS_CT128; start_a[0] = 1'b1;
        d0 = done_cnt_a[0];
        @(posedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_ctl", {busy_a[0], done_a[0], enc_rst_a[0], dec_rst_a[0], pass_enc_a[0], pass_dec_a[0]},
              6'b001100);
        check("midrst_data", key_out_a[0] | 256'(pt_out_a[0]) | 256'(ct_out_a[0]), 0);
        check("midrst_disp", disp_byte_a[0], 8'h00);
        @(negedge clk); reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt_a[0] - d0, 0);
        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128, 1'b0, 1'b0, "after_rst");

`ifdef AES_SELFTEST_LOOP_EN
        pulse_reset();
        @(negedge clk);
        key_in_a[0] = 256'(FIPS_KEY128); plain_a[0] = FIPS_PT; exp_a[0] = FIPS_CT128;
        corrupt_dec_a[0] = 1'b0; start_a[0] = 1'b1;
        wait_done(0, "loop_done1", t1);
        wait_done(0, "loop_done2", t2);
        check("loop_gap12", t2 - t1, 2 * nr_of(4) + 5);
        repeat (3) @(negedge clk);
        start_a[0] = 1'b0;
        wait_done(0, "loop_done3", t3);
        check("loop_gap23", t3 - t2, 2 * nr_of(4) + 5);
        @(negedge clk);
        check("loop_stop", busy_a[0], 1'b0);
        check("loop_run_cnt", run_cnt_a[0], 16'd3);
        check("loop_fail0", fail_sticky_a[0], 1'b0);
        do_run(0, 256'(FIPS_KEY128), FIPS_PT, FIPS_CT128 ^ 128'd1, 1'b0, 1'b0, "loop_bad");
        check("loop_fail1", fail_sticky_a[0], 1'b1);
        check("loop_run_cnt4", run_cnt_a[0], 16'd4);
`else
        // start held high: back-to-back runs separated by one IDLE cycle.
        @(negedge clk);
        key_in_a[0] = 256'(FIPS_KEY128); plain_a[0] = FIPS_PT; exp_a[0] = FIPS_CT128;
        corrupt_dec_a[0] = 1'b0; start_a[0] = 1'b1;
        wait_done(0, "held_done1", t1);
        @(negedge clk);
        check("held_idle", busy_a[0], 1'b0);
        @(negedge clk);
        check("held_restart", busy_a[0], 1'b1);
        wait_done(0, "held_done2", t2);
        start_a[0] = 1'b0;
        check("held_gap", t2 - t1, 2 * nr_of(4) + 6);
        check("held_pass", {pass_enc_a[0], pass_dec_a[0]}, 2'b11);
        repeat (2) @(negedge clk);
`endif

        for (int r = 0; r < 9; r++) begin
            int u = r % NU;
            rk  = rand256() & key_mask(u);
            rp  = rand128();
            rct = enc_model(rk, 4 + 2 * u, rp);
            re  = ($urandom_range(0, 1) == 1) ? rct : rct ^ (128'd1 << $urandom_range(0, 127));
            do_run(u, rk, rp, re, 1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 1))),
                   $sformatf("rand%0d", r));
            disp_check(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $sformatf("rand%0d_disp", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
